// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Assembles one- or two-word instructions and handles stall and redirect.
//
// state | meaning
// S_OP  | fetching an opcode word
// S_IMM | opcode held, fetching its immediate word
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [INSTR_W-1:0] ifid_imm,
    output logic               ifid_has_imm,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic [ADDR_W-1:0]  ifid_pc_next,
    output logic [4:0]         ifid_opcode,
    output logic [2:0]         ifid_rs,
    output logic [2:0]         ifid_rd,
    output logic [3:0]         ifid_shamt
);

    typedef enum logic {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   pc_inc;
    logic [INSTR_W-1:0]  hold_word_q, hold_word_d;
    logic [ADDR_W-1:0]   hold_pc_q, hold_pc_d;

    logic                valid_q, valid_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [INSTR_W-1:0]  imm_q, imm_d;
    logic                has_imm_q, has_imm_d;
    logic [ADDR_W-1:0]   pkt_pc_q, pkt_pc_d;
    logic [ADDR_W-1:0]   pkt_pc_next_q, pkt_pc_next_d;

    assign pc_inc = pc_q + PC_STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_OP;
            pc_q          <= RESET_PC;
            hold_word_q   <= '0;
            hold_pc_q     <= '0;
            valid_q       <= 1'b0;
            instr_q       <= '0;
            imm_q         <= '0;
            has_imm_q     <= 1'b0;
            pkt_pc_q      <= '0;
            pkt_pc_next_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hold_word_q   <= hold_word_d;
            hold_pc_q     <= hold_pc_d;
            valid_q       <= valid_d;
            instr_q       <= instr_d;
            imm_q         <= imm_d;
            has_imm_q     <= has_imm_d;
            pkt_pc_q      <= pkt_pc_d;
            pkt_pc_next_q <= pkt_pc_next_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_word_d   = hold_word_q;
        hold_pc_d     = hold_pc_q;
        valid_d       = valid_q;
        instr_d       = instr_q;
        imm_d         = imm_q;
        has_imm_d     = has_imm_q;
        pkt_pc_d      = pkt_pc_q;
        pkt_pc_next_d = pkt_pc_next_q;

        // Redirect overrides stall; packet payload is left stale behind valid=0.
        if (redirect) begin
            state_d     = S_OP;
            pc_d        = redirect_addr;
            hold_word_d = '0;
            hold_pc_d   = '0;
            valid_d     = 1'b0;
        end else if (!stall) begin
            pc_d = pc_inc;
            case (state_q)
                S_OP: begin
                    if (imem_rdata[0]) begin
                        hold_word_d = imem_rdata;
                        hold_pc_d   = pc_q;
                        valid_d     = 1'b0;
                        state_d     = S_IMM;
                    end else begin
                        valid_d       = 1'b1;
                        instr_d       = imem_rdata;
                        imm_d         = '0;
                        has_imm_d     = 1'b0;
                        pkt_pc_d      = pc_q;
                        pkt_pc_next_d = pc_inc;
                    end
                end
                S_IMM: begin
                    valid_d       = 1'b1;
                    instr_d       = hold_word_q;
                    imm_d         = imem_rdata;
                    has_imm_d     = 1'b1;
                    pkt_pc_d      = hold_pc_q;
                    pkt_pc_next_d = pc_inc;
                    state_d       = S_OP;
                end
                default: state_d = S_OP;
            endcase
        end
    end

    assign imem_addr    = pc_q;
    assign ifid_valid   = valid_q;
    assign ifid_instr   = instr_q;
    assign ifid_imm     = imm_q;
    assign ifid_has_imm = has_imm_q;
    assign ifid_pc      = pkt_pc_q;
    assign ifid_pc_next = pkt_pc_next_q;
    assign ifid_opcode  = instr_q[15:11];
    assign ifid_rs      = instr_q[10:8];
    assign ifid_rd      = instr_q[7:5];
    assign ifid_shamt   = instr_q[4:1];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random stall/redirect traffic,
// compared against an instruction-stream model built from memory contents.
module tb_fetch_unit;

    localparam int AW = 8;
    localparam int IW = 16;
    localparam logic [AW-1:0] RPC = 8'h10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall;
    logic          redirect;
    logic [AW-1:0] redirect_addr;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    logic          ifid_valid;
    logic [IW-1:0] ifid_instr;
    logic [IW-1:0] ifid_imm;
    logic          ifid_has_imm;
    logic [AW-1:0] ifid_pc;
    logic [AW-1:0] ifid_pc_next;
    logic [4:0]    ifid_opcode;
    logic [2:0]    ifid_rs;
    logic [2:0]    ifid_rd;
    logic [3:0]    ifid_shamt;

    logic [IW-1:0] mem [256];

    int errors = 0;
    int checks = 0;

    // Model: current fetch address, any half-assembled instruction, last packet.
    logic [AW-1:0] m_pc;
    bit            m_pend;
    logic [IW-1:0] m_pend_word;
    logic [AW-1:0] m_pend_pc;
    bit            m_valid;
    logic [IW-1:0] m_instr, m_imm;
    bit            m_has_imm;
    logic [AW-1:0] m_ppc, m_ppc_next;

    fetch_unit #(
        .ADDR_W  (AW),
        .INSTR_W (IW),
        .RESET_PC(RPC),
        .PC_STEP (8'd1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .ifid_valid   (ifid_valid),
        .ifid_instr   (ifid_instr),
        .ifid_imm     (ifid_imm),
        .ifid_has_imm (ifid_has_imm),
        .ifid_pc      (ifid_pc),
        .ifid_pc_next (ifid_pc_next),
        .ifid_opcode  (ifid_opcode),
        .ifid_rs      (ifid_rs),
        .ifid_rd      (ifid_rd),
        .ifid_shamt   (ifid_shamt)
    );

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = RPC;
        m_pend    = 0;
        m_valid   = 0;
        m_instr   = '0;
        m_imm     = '0;
        m_has_imm = 0;
        m_ppc     = '0;
        m_ppc_next = '0;
    endtask

    task automatic emit(input logic [IW-1:0] w, input logic [IW-1:0] imm, input bit has,
                        input logic [AW-1:0] at, input logic [AW-1:0] after);
        m_valid    = 1;
        m_instr    = w;
        m_imm      = imm;
        m_has_imm  = has;
        m_ppc      = at;
        m_ppc_next = after;
    endtask

    // One clock edge of the fetch rules: consume the word at m_pc.
    task automatic model_edge();
        logic [IW-1:0] w;
        logic [AW-1:0] nxt;
        if (redirect) begin
            m_pc    = redirect_addr;
            m_pend  = 0;
            m_valid = 0;
        end else if (!stall) begin
            w   = mem[m_pc];
            nxt = m_pc + 8'd1;
            if (m_pend) begin
                emit(m_pend_word, w, 1, m_pend_pc, nxt);
                m_pend = 0;
            end else if (w[0]) begin
                m_pend      = 1;
                m_pend_word = w;
                m_pend_pc   = m_pc;
                m_valid     = 0;
            end else begin
                emit(w, '0, 0, m_pc, nxt);
            end
            m_pc = nxt;
        end
    endtask

    task automatic compare_all();
        chk("imem_addr", imem_addr, m_pc);
        chk("ifid_valid", ifid_valid, m_valid);
        if (m_valid) begin
            chk("ifid_instr", ifid_instr, m_instr);
            chk("ifid_imm", ifid_imm, m_imm);
            chk("ifid_has_imm", ifid_has_imm, m_has_imm);
            chk("ifid_pc", ifid_pc, m_ppc);
            chk("ifid_pc_next", ifid_pc_next, m_ppc_next);
            chk("ifid_opcode", ifid_opcode, m_instr[15:11]);
            chk("ifid_rs", ifid_rs, m_instr[10:8]);
            chk("ifid_rd", ifid_rd, m_instr[7:5]);
            chk("ifid_shamt", ifid_shamt, m_instr[4:1]);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_imem_addr"}, imem_addr, RPC);
        chk({tag, "_valid"}, ifid_valid, 1'b0);
        chk({tag, "_instr"}, ifid_instr, 16'h0);
        chk({tag, "_imm"}, ifid_imm, 16'h0);
        chk({tag, "_has_imm"}, ifid_has_imm, 1'b0);
        chk({tag, "_pc"}, ifid_pc, 8'h0);
        chk({tag, "_pc_next"}, ifid_pc_next, 8'h0);
        chk({tag, "_fields"}, {ifid_opcode, ifid_rs, ifid_rd, ifid_shamt}, 15'h0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h5A42; mem[1] = 16'h1234; mem[2] = 16'h0864; mem[3] = 16'hF8E0;
        mem[4] = 16'h0801; mem[5] = 16'hBEEF;
        mem[6] = 16'h0803; mem[7] = 16'h1111;
        mem[8] = 16'h2001; mem[9] = 16'h7777;
        mem[8'h40] = 16'h3000;
        mem[8'hFF] = 16'h0002;
        mem[8'h20] = 16'h0001;

        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_addr = '0;
        model_reset();
        #12;
        chk_reset_state("reset");
        rst_n = 1'b1;

        // Redirect to 0, then the four one-word instructions
        redirect = 1'b1; redirect_addr = 8'h00;
        step();
        redirect = 1'b0;
        step();
        chk("ex_pc0", ifid_pc, 8'h00);
        chk("ex_opcode", ifid_opcode, 5'h0B);
        chk("ex_rs", ifid_rs, 3'd2);
        chk("ex_rd", ifid_rd, 3'd2);
        chk("ex_shamt", ifid_shamt, 4'd1);
        step();
        step();
        chk("ex_pc2_next", ifid_pc_next, 8'h03);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", ifid_pc, 8'h02);
            chk("stall_addr", imem_addr, 8'h03);
        end
        stall = 1'b0;
        step();
        chk("resume_pc3", ifid_pc, 8'h03);

        step();
        chk("twoword_bubble", ifid_valid, 1'b0);
        step();
        chk("twoword_imm", ifid_imm, 16'hBEEF);
        chk("twoword_pc_next", ifid_pc_next, 8'h06);
        chk("twoword_next_fetch", imem_addr, 8'h06);

        step();
        stall = 1'b1;
        step();
        step();
        stall = 1'b0;
        step();
        chk("simm_stall_imm", ifid_imm, 16'h1111);

        step();
        stall = 1'b1; redirect = 1'b1; redirect_addr = 8'h40;
        step();
        chk("redir_valid", ifid_valid, 1'b0);
        chk("redir_addr", imem_addr, 8'h40);
        stall = 1'b0; redirect = 1'b0;
        step();
        chk("redir_pkt_pc", ifid_pc, 8'h40);

        redirect = 1'b1; redirect_addr = 8'hFF;
        step();
        redirect = 1'b0;
        step();
        chk("wrap_pc", ifid_pc, 8'hFF);
        chk("wrap_pc_next", ifid_pc_next, 8'h00);
        chk("wrap_fetch", imem_addr, 8'h00);

        // Reset while the instruction at 0x20 is half-fetched
        redirect = 1'b1; redirect_addr = 8'h20;
        step();
        redirect = 1'b0;
        step();
        mem[8'h10] = 16'h4000;
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_reset_state("midreset");
        #2;
        rst_n = 1'b1;
        step();
        chk("post_reset_pc", ifid_pc, 8'h10);
        chk("post_reset_instr", ifid_instr, 16'h4000);

        for (int i = 0; i < 400; i++) begin
            stall         = ($urandom_range(0, 4) == 0);
            redirect      = ($urandom_range(0, 11) == 0);
            redirect_addr = 8'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage with IF/ID pipeline register. Holds the program counter, drives the instruction-memory address, and assembles one- or two-word instructions (opcode word plus optional immediate word) into a single IF/ID packet. Supports pipeline stall and taken-jump/branch redirect with flush. Sits between the instruction memory and the decode stage.

## Interface
Parameters:
- ADDR_W, 32, PC and instruction-memory address width
- INSTR_W, 16, instruction word width (minimum 16)
- RESET_PC, 0, PC value after reset
- PC_STEP, 1, PC increment per fetched word

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold PC, state and IF/ID register
- redirect  in  1  taken jump/branch/flush request
- redirect_addr  in  ADDR_W  new PC on redirect
- imem_addr  out  ADDR_W  instruction-memory address, combinationally equal to PC
- imem_rdata  in  INSTR_W  instruction word at imem_addr, valid same cycle (combinational read)
- ifid_valid  out  1  IF/ID packet holds a real instruction
- ifid_instr  out  INSTR_W  opcode word
- ifid_imm  out  INSTR_W  immediate word (0 when none)
- ifid_has_imm  out  1  packet carries an immediate
- ifid_pc  out  ADDR_W  address of opcode word
- ifid_pc_next  out  ADDR_W  address after last word of the instruction
- ifid_opcode  out  5  ifid_instr[15:11]
- ifid_rs  out  3  ifid_instr[10:8]
- ifid_rd  out  3  ifid_instr[7:5]
- ifid_shamt  out  4  ifid_instr[4:1]

## Operation
- Word field map: bit0 = has-immediate, [4:1] shift amount, [7:5] Rd, [10:8] Rs, [15:11] opcode; fields are non-overlapping. Decoded outputs are wires off ifid_instr.
- States: S_OP (fetch opcode word), S_IMM (fetch immediate word).
- Per-edge priority: reset > redirect > stall > normal.
- S_OP, normal: if imem_rdata[0]=0, load packet {valid=1, instr=rdata, imm=0, has_imm=0, pc=PC, pc_next=PC+PC_STEP}; PC<=PC+PC_STEP; stay S_OP. If imem_rdata[0]=1, capture rdata and PC into internal hold registers, PC<=PC+PC_STEP, ifid_valid<=0 (bubble), go S_IMM.
- S_IMM, normal: load packet {valid=1, instr=hold word, imm=imem_rdata, has_imm=1, pc=hold PC, pc_next=PC+PC_STEP}; PC<=PC+PC_STEP; go S_OP.
- Redirect (either state, stall ignored): PC<=redirect_addr, ifid_valid<=0, discard hold registers, go S_OP. Other ifid_* fields may keep stale values; consumers qualify on ifid_valid.
- Stall without redirect: PC, state, hold registers and all ifid_* outputs unchanged.
- PC arithmetic is modulo 2^ADDR_W; wrap from max address to 0 is legal and silent.

## Timing
- Reset (async assert, any time): PC=RESET_PC, state=S_OP, ifid_valid=0, all other ifid_* = 0, hold registers = 0. imem_addr follows PC immediately. Deassertion takes effect at the next rising edge.
- Reset mid S_IMM aborts the pending two-word instruction; no packet is emitted for it.
- Latency: one-word instruction at PC appears on IF/ID at the edge it is fetched (1 cycle); two-word instruction appears one edge later than its opcode fetch, preceded by one bubble cycle.
- Throughput: 1 instruction/cycle for one-word instructions, 1 per 2 cycles for two-word instructions.
- Redirect and stall in the same cycle: redirect wins. Redirect in S_IMM: the half-fetched instruction is dropped.
- Redirect's first instruction reaches IF/ID on the edge after the redirect edge.

## Test plan
- Reset: drive rst_n=0 mid-cycle with RESET_PC=0x10 -> PC=0x10, imem_addr=0x10, ifid_valid=0 immediately, all ifid_* = 0.
- Sequential one-word: memory 0x0000..0x0003 = 0x5A42,0x1234,0x0864,0xF8E0 -> four consecutive valid packets, pc=0..3, pc_next=1..4; for 0x5A42 opcode=0x0B, rs=2, rd=2, shamt=1.
- Two-word: word@4=0x0801, word@5=0xBEEF -> cycle with ifid_valid=0, then packet instr=0x0801, imm=0xBEEF, has_imm=1, pc=4, pc_next=6; next fetch at 6.
- Stall: assert stall 3 cycles after packet pc=2 -> ifid_* and imem_addr frozen 3 cycles, then pc=3 resumes; stall during S_IMM holds state and completes afterwards.
- Redirect: redirect=1, redirect_addr=0x40 while in S_IMM (also with stall=1) -> ifid_valid=0 next edge, imem_addr=0x40, next packet pc=0x40; dropped instruction never appears.
- Wrap: ADDR_W=4, PC=0xF, one-word instruction -> packet pc=0xF, pc_next=0x0, next fetch at 0x0.
